// File: rtl/line_buffer_frame_arbiter.sv
// line_buffer_frame_arbiter: frame-atomic round-robin arbiter sharing one 3x3 line buffer
// between two pixel streams, with inter-line gaps and a post-frame drain.
module line_buffer_frame_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int WIDTH        = 5,
    parameter int HEIGHT       = 5,
    parameter int LINE_GAP     = 3,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    input  logic                  s0_sof,
    input  logic [DATA_WIDTH-1:0] s0_data,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic                  s1_sof,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  s1_ready,
    output logic                  lb_in_valid,
    output logic [DATA_WIDTH-1:0] lb_pix_in,
    output logic                  owner,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_sof
);
    localparam int CLW  = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int RW   = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int MAXC = LINE_GAP > DRAIN_CYCLES ? LINE_GAP : DRAIN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DRAIN} state_t;

    state_t                r_state, w_next;
    logic                  r_owner, r_rr_last, r_lb_valid, r_frame_done, r_err_sof;
    logic [DATA_WIDTH-1:0] r_lb_pix;
    logic [CLW-1:0]        r_col;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_cnt;
    logic                  w_req0, w_req1, w_req, w_grant, w_valid, w_sof, w_acc, w_eol, w_eof;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_req0  = s0_valid && s0_sof;
    assign w_req1  = s1_valid && s1_sof;
    assign w_req   = w_req0 || w_req1;
    assign w_grant = (w_req0 && w_req1) ? !r_rr_last : w_req1;
    assign w_valid = r_owner ? s1_valid : s0_valid;
    assign w_sof   = r_owner ? s1_sof : s0_sof;
    assign w_data  = r_owner ? s1_data : s0_data;
    assign w_acc   = (r_state == STREAM) && w_valid;
    assign w_eol   = r_col == CLW'(WIDTH - 1);
    assign w_eof   = w_eol && (r_row == RW'(HEIGHT - 1));

    assign s0_ready    = (r_state == STREAM) && !r_owner;
    assign s1_ready    = (r_state == STREAM) && r_owner;
    assign lb_in_valid = r_lb_valid;
    assign lb_pix_in   = r_lb_pix;
    assign owner       = r_owner;
    assign busy        = r_state != IDLE;
    assign frame_done  = r_frame_done;
    assign err_sof     = r_err_sof;

    // The drain count starts on the cycle that shows the last pixel, so DRAIN_CYCLES
    // fully idle cycles follow it before frame_done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? STREAM : IDLE;
            STREAM:  if (w_acc && w_eol) w_next = w_eof ? DRAIN : (LINE_GAP > 0 ? GAP : STREAM);
            GAP:     w_next = (r_cnt == CW'(LINE_GAP - 1)) ? STREAM : GAP;
            DRAIN:   w_next = (r_cnt == CW'(DRAIN_CYCLES)) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_rr_last    <= 1'b1;
            r_lb_valid   <= 1'b0;
            r_lb_pix     <= '0;
            r_frame_done <= 1'b0;
            r_err_sof    <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_next;
            r_lb_valid   <= w_acc;
            r_frame_done <= (r_state == DRAIN) && (w_next == IDLE);
            r_err_sof    <= w_acc && w_sof && (r_col != '0 || r_row != '0);
            r_cnt        <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (w_acc) r_lb_pix <= w_data;
            if (r_state == IDLE && w_req) r_owner <= w_grant;
            if (r_state == DRAIN && w_next == IDLE) r_rr_last <= r_owner;
            if (w_acc) begin
                r_col <= w_eol ? '0 : r_col + 1'b1;
                if (w_eol) r_row <= w_eof ? '0 : r_row + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_frame_arbiter.sv
// tb_line_buffer_frame_arbiter: two arbiter instances (default and LINE_GAP=0/DRAIN_CYCLES=1)
// driven by randomized pixel sources and checked each cycle against a timeline model.
module tb_line_buffer_frame_arbiter;
    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v[2][2], sf[2][2], rdy[2][2];
    logic [7:0] d[2][2];
    logic       o_lbv[2], o_own[2], o_busy[2], o_fd[2], o_err[2];
    logic [7:0] o_pix[2];

    int total = 0, bad = 0, cyc = 0;
    bit en[2], rearm, pend[2][2], acc_s[2][2];
    int stall_pct, err_pct, hold_at, err_at;
    int hold_left[2], pix[2][2];

    bit m_act[2], m_own[2], m_rr[2], e_lbv[2], e_fd[2], e_err[2];
    int m_npix[2], m_res[2], m_done[2];
    logic [7:0] e_pix[2];

    int q_lbv[2][$], q_err[2][$], fd_cyc[2][$], fd_own[2][$];

    always #5 clk = ~clk;

    line_buffer_frame_arbiter #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H), .LINE_GAP(3), .DRAIN_CYCLES(8)) u0 (
        .clk(clk), .rst(rst),
        .s0_valid(v[0][0]), .s0_sof(sf[0][0]), .s0_data(d[0][0]), .s0_ready(rdy[0][0]),
        .s1_valid(v[0][1]), .s1_sof(sf[0][1]), .s1_data(d[0][1]), .s1_ready(rdy[0][1]),
        .lb_in_valid(o_lbv[0]), .lb_pix_in(o_pix[0]), .owner(o_own[0]), .busy(o_busy[0]),
        .frame_done(o_fd[0]), .err_sof(o_err[0]));

    line_buffer_frame_arbiter #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H), .LINE_GAP(0), .DRAIN_CYCLES(1)) u1 (
        .clk(clk), .rst(rst),
        .s0_valid(v[1][0]), .s0_sof(sf[1][0]), .s0_data(d[1][0]), .s0_ready(rdy[1][0]),
        .s1_valid(v[1][1]), .s1_sof(sf[1][1]), .s1_data(d[1][1]), .s1_ready(rdy[1][1]),
        .lb_in_valid(o_lbv[1]), .lb_pix_in(o_pix[1]), .owner(o_own[1]), .busy(o_busy[1]),
        .frame_done(o_fd[1]), .err_sof(o_err[1]));

    function automatic int gap_of(int i);
        return i == 0 ? 3 : 0;
    endfunction

    function automatic int drain_of(int i);
        return i == 0 ? 8 : 1;
    endfunction

    function automatic int exp_rdy(int i, int s);
        return int'(m_act[i] && int'(m_own[i]) == s && m_npix[i] < N && cyc >= m_res[i]);
    endfunction

    task automatic chk(string nm, int i, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s inst%0d cyc%0d: got %0d want %0d", nm, i, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_own[i] = 0; m_rr[i] = 1; m_npix[i] = 0; m_res[i] = 0; m_done[i] = 0;
            e_lbv[i] = 0; e_fd[i] = 0; e_err[i] = 0; e_pix[i] = '0;
        end
    endtask

    // Timeline model: grants, pixel counts and the absolute cycles at which
    // streaming resumes after a line gap and at which frame_done must appear.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit r0, r1, acc, nl, nf, ne;
            r0 = v[i][0] && sf[i][0];
            r1 = v[i][1] && sf[i][1];
            acc = m_act[i] && v[i][m_own[i]] && exp_rdy(i, int'(m_own[i])) == 1;
            nl = 0; nf = 0; ne = 0;
            if (!m_act[i]) begin
                if (r0 || r1) begin
                    m_own[i] = (r0 && r1) ? !m_rr[i] : r1;
                    m_act[i] = 1; m_npix[i] = 0; m_res[i] = cyc + 1; m_done[i] = 0;
                end
            end else if (acc) begin
                nl = 1;
                e_pix[i] = d[i][m_own[i]];
                ne = sf[i][m_own[i]] && m_npix[i] != 0;
                m_npix[i]++;
                if (m_npix[i] == N) m_done[i] = cyc + drain_of(i) + 2;
                else if (m_npix[i] % W == 0) m_res[i] = cyc + 1 + gap_of(i);
            end
            if (m_act[i] && m_npix[i] == N && cyc + 1 == m_done[i]) begin
                m_act[i] = 0; nf = 1; m_rr[i] = m_own[i];
            end
            e_lbv[i] = nl; e_fd[i] = nf; e_err[i] = ne;
        end
        cyc++;
    endtask

    task automatic check();
        for (int i = 0; i < 2; i++) begin
            if (o_lbv[i] === 1'b1) q_lbv[i].push_back(cyc);
            if (o_err[i] === 1'b1) q_err[i].push_back(cyc);
            if (o_fd[i] === 1'b1) begin
                fd_cyc[i].push_back(cyc);
                fd_own[i].push_back(int'(o_own[i]));
            end
            chk("owner", i, int'(o_own[i]), int'(m_own[i]));
            chk("busy", i, int'(o_busy[i]), int'(m_act[i]));
            chk("lb_in_valid", i, int'(o_lbv[i]), int'(e_lbv[i]));
            if (e_lbv[i]) chk("lb_pix_in", i, int'(o_pix[i]), int'(e_pix[i]));
            chk("frame_done", i, int'(o_fd[i]), int'(e_fd[i]));
            chk("err_sof", i, int'(o_err[i]), int'(e_err[i]));
            chk("s0_ready", i, int'(rdy[i][0]), exp_rdy(i, 0));
            chk("s1_ready", i, int'(rdy[i][1]), exp_rdy(i, 1));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 2; s++) begin
                bit st;
                st = $urandom_range(99) < stall_pct;
                if (s == 0 && pix[i][0] == hold_at && hold_left[i] > 0) begin
                    st = 1;
                    hold_left[i]--;
                end
                v[i][s]  = en[s] && pend[i][s] && !st;
                sf[i][s] = pix[i][s] == 0 || pix[i][s] == err_at || $urandom_range(99) < err_pct;
                d[i][s]  = 8'(s * 100 + pix[i][s] + 1);
            end
    endtask

    task automatic step();
        check();
        drive();
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 2; s++) acc_s[i][s] = rdy[i][s] && v[i][s];
        model_step();
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 2; s++)
                if (acc_s[i][s]) begin
                    pix[i][s]++;
                    if (pix[i][s] == N) begin
                        pix[i][s] = 0;
                        pend[i][s] = rearm;
                    end
                end
        @(negedge clk);
    endtask

    task automatic src_reset();
        for (int i = 0; i < 2; i++) begin
            hold_left[i] = 0;
            q_lbv[i].delete(); q_err[i].delete(); fd_cyc[i].delete(); fd_own[i].delete();
            for (int s = 0; s < 2; s++) begin
                pix[i][s] = 0; pend[i][s] = 0; v[i][s] = 0; sf[i][s] = 0; d[i][s] = '0;
            end
        end
        stall_pct = 0; err_pct = 0; hold_at = -1; err_at = -1; rearm = 0; en[0] = 0; en[1] = 0;
    endtask

    task automatic phase_reset();
        rst = 1'b1;
        model_reset();
        src_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic arm(bit e0, bit e1);
        en[0] = e0; en[1] = e1;
        for (int i = 0; i < 2; i++) begin
            pend[i][0] = e0; pend[i][1] = e1;
        end
    endtask

    task automatic run_frames(string nm, int target, int limit);
        int n = 0;
        while ((fd_cyc[0].size() < target || fd_cyc[1].size() < target) && n < limit) begin
            step();
            n++;
        end
        for (int i = 0; i < 2; i++) chk(nm, i, int'(fd_cyc[i].size() >= target), 1);
    endtask

    initial begin
        @(negedge clk);
        phase_reset();

        // single frame from s0, pixels 1..25, no stalls
        arm(1, 0);
        run_frames("A_frames", 1, 300);
        for (int i = 0; i < 2; i++) begin
            chk("A_count", i, q_lbv[i].size(), 25);
            if (q_lbv[i].size() == 25 && fd_cyc[i].size() > 0) begin
                chk("A_line_gap", i, q_lbv[i][5] - q_lbv[i][4], i == 0 ? 4 : 1);
                chk("A_drain", i, fd_cyc[i][0] - q_lbv[i][24], i == 0 ? 9 : 2);
                chk("A_span", i, fd_cyc[i][0] - q_lbv[i][0], i == 0 ? 45 : 26);
                chk("A_owner", i, fd_own[i][0], 0);
            end
        end

        // both request continuously: grants must alternate 0,1,0
        phase_reset();
        rearm = 1;
        arm(1, 1);
        run_frames("B_frames", 3, 600);
        for (int i = 0; i < 2; i++)
            if (fd_own[i].size() >= 3) begin
                chk("B_own0", i, fd_own[i][0], 0);
                chk("B_own1", i, fd_own[i][1], 1);
                chk("B_own2", i, fd_own[i][2], 0);
            end

        // 4-cycle stall before pixel 13 plus a stray sof on pixel 7
        phase_reset();
        hold_at = 12;
        err_at = 6;
        hold_left[0] = 4; hold_left[1] = 4;
        arm(1, 0);
        run_frames("C_frames", 1, 300);
        for (int i = 0; i < 2; i++) begin
            chk("C_count", i, q_lbv[i].size(), 25);
            chk("C_err_count", i, q_err[i].size(), 1);
            if (q_lbv[i].size() == 25 && fd_cyc[i].size() > 0 && q_err[i].size() == 1) begin
                chk("C_span", i, fd_cyc[i][0] - q_lbv[i][0], i == 0 ? 49 : 30);
                chk("C_err_at_pix7", i, q_err[i][0], q_lbv[i][6]);
            end
        end

        // reset in the middle of an s1 frame, then a fresh s1 frame
        phase_reset();
        arm(0, 1);
        begin
            int n = 0;
            while (pix[0][1] != 9 && n < 100) begin
                step();
                n++;
            end
            chk("D_reached_pix9", 0, pix[0][1], 9);
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("D_rst_lbv", i, int'(o_lbv[i]), 0);
            chk("D_rst_busy", i, int'(o_busy[i]), 0);
            chk("D_rst_owner", i, int'(o_own[i]), 0);
        end
        model_reset();
        src_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        arm(0, 1);
        run_frames("D_frames", 1, 300);
        for (int i = 0; i < 2; i++) begin
            chk("D_count", i, q_lbv[i].size(), 25);
            if (fd_own[i].size() > 0) chk("D_owner", i, fd_own[i][0], 1);
        end

        // randomized traffic: stalls, stray sofs, contention
        phase_reset();
        rearm = 1;
        stall_pct = 30;
        err_pct = 5;
        arm(1, 1);
        for (int n = 0; n < 3000; n++) step();
        for (int i = 0; i < 2; i++) chk("E_progress", i, int'(fd_cyc[i].size() >= 4), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_buffer_frame_arbiter.md
Name: line_buffer_frame_arbiter

Overview:
- Frame-atomic arbiter that shares one line_buffer_3x3 instance between two pixel-stream requesters.
- Grants a whole WIDTH x HEIGHT frame to one requester and forwards its pixels to the line buffer as in_valid/pix_in.
- Optionally inserts inter-line gap cycles, then holds a drain period so the last windows flush before the buffer is re-granted.
- Sits between the two camera/DMA sources and the line buffer; round-robin fair at frame granularity.

Parameters:
- DATA_WIDTH, 8, pixel width
- WIDTH, 5, pixels per line
- HEIGHT, 5, lines per frame
- LINE_GAP, 3, idle cycles forced after each line except the last (0 = none)
- DRAIN_CYCLES, 8, idle cycles after the last pixel before frame_done and re-arbitration (>=1)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- s0_valid  in  1  requester 0 pixel valid
- s0_sof  in  1  requester 0 start-of-frame, qualifies first pixel
- s0_data  in  DATA_WIDTH  requester 0 pixel
- s0_ready  out  1  requester 0 accept
- s1_valid, s1_sof, s1_data, s1_ready  same as requester 0, for requester 1
- lb_in_valid  out  1  to line buffer in_valid
- lb_pix_in  out  DATA_WIDTH  to line buffer pix_in
- owner  out  1  index of the current/last granted requester
- busy  out  1  high in STREAM, GAP and DRAIN
- frame_done  out  1  one-cycle pulse at end of drain
- err_sof  out  1  one-cycle pulse: owner sent sof on a non-first pixel

Behaviour:
- Reset (async, immediate): state=IDLE, lb_in_valid=0, lb_pix_in=0, owner=0, busy=0, frame_done=0, err_sof=0, col=row=0, rr_last=1 (requester 0 wins the first tie).
- Request: requester r requests when sr_valid && sr_sof.
- IDLE:
  - All ready=0; no pixel is accepted in IDLE.
  - On request(s), register owner: a single requester is granted; on a tie the winner is !rr_last.
  - Next state STREAM. Grant-to-first-ready latency is 1 cycle.
- STREAM:
  - s[owner]_ready=1 and the other ready=0. Ready is combinational from state/owner only, never from valid.
  - On accept (valid && ready): the next cycle shows lb_in_valid=1 and lb_pix_in=data, a 1-cycle registered latency. Otherwise lb_in_valid=0.
  - col increments per accept. At col=WIDTH-1, col wraps to 0 and row increments.
  - After the last pixel of a line, if row<HEIGHT-1 and LINE_GAP>0, go to GAP; else stay in STREAM.
  - After pixel (HEIGHT-1, WIDTH-1), go to DRAIN.
- GAP: ready=0 for exactly LINE_GAP cycles, then STREAM.
- DRAIN:
  - ready=0 and lb_in_valid=0 for DRAIN_CYCLES cycles.
  - In the final cycle, register frame_done=1 for one cycle, set rr_last=owner, go to IDLE.
  - owner keeps its value through IDLE until the next grant.
- err_sof: an accepted owner pixel with sof=1 and (row,col)!=(0,0) pulses err_sof next cycle. The pixel is still forwarded as ordinary data; counters are unaffected.
- Non-owner valid/sof is ignored for the whole frame, with no data loss: its ready is held 0.
- Owner valid low mid-line: counters hold and lb_in_valid=0 that cycle; there is no timeout.
- Counters use $clog2 widths; no arithmetic overflow is possible because of the explicit wrap at WIDTH-1 / HEIGHT-1.
- Reset mid-frame: everything returns to the reset values asynchronously. The partial frame is abandoned and the next frame requires a fresh sof.

Test Plan:
- Single frame on s0 (pixels 1..25, sof on 1, valid every cycle): lb_in_valid high for 5 consecutive cycles per line with pix 1..5, 6..10, ...; 3 low cycles between lines; after pix 25, 8 low cycles, then frame_done pulse; owner=0; s1_ready stays 0.
- Tie: s0 and s1 both assert sof in IDLE after reset: s0 granted first. On frame_done, s1 (still requesting) is granted with owner=1 one cycle after returning to IDLE. A second simultaneous tie then grants s0.
- Stall: owner drops valid for 4 cycles after pixel 12: lb_in_valid low exactly those cycles, pixel 13 follows, total still 25 forwarded pixels, frame_done timing shifts by 4 cycles.
- Protocol error: s0 asserts sof on pixel 7: err_sof pulses one cycle after that accept, pixel 7 is forwarded normally, and the frame still completes at 25 pixels.
- Reset mid-frame: rst asserted after pixel 9: lb_in_valid=0, busy=0, owner=0 immediately. After release, s1 sof is granted and forwards its full 25 pixels from (0,0).
- LINE_GAP=0, DRAIN_CYCLES=1: a 25-pixel frame is forwarded back-to-back in 25 cycles; frame_done is asserted 2 cycles after the last lb_in_valid.
